// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage:
//   - alu_sel_e : ALU select codes
//   - FLAG_*    : bit positions of Z/N/C/V inside the 4-bit flag vector
//   - WIDTH_DEF : default datapath width
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        SEL_PASS_A   = 3'b000,
        SEL_SUB      = 3'b001,
        SEL_ADD      = 3'b010,
        SEL_ADD_INC  = 3'b011,
        SEL_ADD_NOTB = 3'b100,
        SEL_SUB_ALT  = 3'b101,
        SEL_DEC      = 3'b110,
        SEL_PASS_B   = 3'b111
    } alu_sel_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_flag_calc.sv
// ----------------------------------------------------------------------------
// alu_flag_calc
// Combinational recomputation of the ALU result and derivation of the
// condition flags for one operation.
// Ports:
//   i_a, i_b    : operands presented to the ALU
//   i_sel       : ALU select code
//   i_y         : result produced by the ALU
//   o_flags     : {Z,N,C,V}; Z/N from i_y, C/V from the recomputed sum
//   o_mismatch  : i_y differs from the recomputed result
// ----------------------------------------------------------------------------
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_sel,
    input  logic [WIDTH-1:0] i_y,
    output logic [3:0]       o_flags,
    output logic             o_mismatch
);

    logic [WIDTH-1:0] w_op2;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_v;

    // Every arithmetic select is a + op2 + cin; only op2/cin differ.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_op2   = '1;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (alu_sel_e'(i_sel))
            SEL_PASS_A:   w_arith = 1'b0;
            SEL_SUB:      begin w_op2 = ~i_b; w_cin = 1'b1; end
            SEL_ADD:      begin w_op2 =  i_b; w_cin = 1'b0; end
            SEL_ADD_INC:  begin w_op2 =  i_b; w_cin = 1'b1; end
            SEL_ADD_NOTB: begin w_op2 = ~i_b; w_cin = 1'b0; end
            SEL_SUB_ALT:  begin w_op2 = ~i_b; w_cin = 1'b1; end
            SEL_DEC:      begin w_op2 = '1;   w_cin = 1'b0; end
            SEL_PASS_B:   w_arith = 1'b0;
            default:      w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_r = w_sum[WIDTH-1:0];
        w_c = 1'b0;
        w_v = 1'b0;
        if (w_arith) begin
            w_c = w_sum[WIDTH];
            // Signed overflow: operands agree in sign, result sign differs.
            w_v = (i_a[WIDTH-1] == w_op2[WIDTH-1]) && (w_r[WIDTH-1] != i_a[WIDTH-1]);
        end else if (alu_sel_e'(i_sel) == SEL_PASS_B) begin
            w_r = i_b;
        end else begin
            w_r = i_a;
        end
    end

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_y == '0);
        o_flags[FLAG_N] = i_y[WIDTH-1];
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_V] = w_v;
    end

    assign o_mismatch = (i_y != w_r);

endmodule : alu_flag_calc

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
// Registers each ALU result with its flags and select code into a 2-entry
// in-order buffer with valid/ready on both sides. Also keeps a sticky
// self-check error and a saturating count of accepted operations.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready = buffer not full)
//   in_a, in_b, in_sel    : operands and select presented to the ALU
//   in_y                  : ALU result
//   out_valid / out_ready : downstream handshake for the head entry
//   out_y, out_flags, out_sel : head entry fields ({Z,N,C,V} flags)
//   chk_err               : sticky, some accepted in_y was wrong
//   op_count              : accepted operations, saturating
// ----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2,       // only 2 is supported
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    output logic [2:0]       out_sel,
    output logic             chk_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [3:0]       w_flags;
    logic             w_mismatch;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head_y;
    logic [3:0]       r_head_flags;
    logic [2:0]       r_head_sel;
    logic [WIDTH-1:0] r_tail_y;
    logic [3:0]       r_tail_flags;
    logic [2:0]       r_tail_sel;
    logic             r_chk_err;
    logic [CNT_W-1:0] r_op_count;

    alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .i_a        (in_a),
        .i_b        (in_b),
        .i_sel      (in_sel),
        .i_y        (in_y),
        .o_flags    (w_flags),
        .o_mismatch (w_mismatch)
    );

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Head entry drives out_* directly, so it holds its value when empty.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 2'd0;
            r_head_y     <= '0;
            r_head_flags <= '0;
            r_head_sel   <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_y     <= in_y;
                        r_head_flags <= w_flags;
                        r_head_sel   <= in_sel;
                        r_count      <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_y     <= in_y;
                        r_head_flags <= w_flags;
                        r_head_sel   <= in_sel;
                    end else if (w_push) begin
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (w_pop) begin
                        r_head_y     <= r_tail_y;
                        r_head_flags <= r_tail_flags;
                        r_head_sel   <= r_tail_sel;
                        r_count      <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    // Tail is only read when r_count==2, which requires a write first.
    // NOTE: storage that is never observed before being written needs no reset.
    always_ff @(posedge clk) begin
        if (w_push && (r_count == 2'd1) && !w_pop) begin
            r_tail_y     <= in_y;
            r_tail_flags <= w_flags;
            r_tail_sel   <= in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err  <= 1'b0;
            r_op_count <= '0;
        end else if (w_push) begin
            if (w_mismatch) begin
                r_chk_err <= 1'b1;
            end
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign out_y     = r_head_y;
    assign out_flags = r_head_flags;
    assign out_sel   = r_head_sel;
    assign chk_err   = r_chk_err;
    assign op_count  = r_op_count;

endmodule : alu_result_stage

// File: tb/tb_alu_result_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_result_stage
// Directed-vector bench for alu_result_stage with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_sel;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_flags;
    logic [2:0]  out_sel;
    logic        chk_err;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .out_sel   (out_sel),
        .chk_err   (chk_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] y);
        in_valid = 1'b1;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_y     = y;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sel    = '0;
        in_y      = '0;
        out_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_chk_err",   chk_err,   0);
        check("rst_op_count",  op_count,  0);
        check("rst_out_y",     out_y,     0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_sel",   out_sel,   0);
        tick();
        check("idle_out_valid", out_valid, 0);

        // Add overflow
        drive(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        tick();
        in_valid = 1'b0;
        check("addov_out_y",     out_y,     32'h8000_0000);
        check("addov_flags",     out_flags, 4'b0101);
        check("addov_out_valid", out_valid, 1);
        check("addov_out_sel",   out_sel,   3'b010);
        check("addov_op_count",  op_count,  1);

        // Pop; outputs hold while empty
        out_ready = 1'b1;
        tick();
        check("pop_out_valid", out_valid, 0);
        check("hold_out_y",    out_y,     32'h8000_0000);
        tick();
        check("empty_pop_valid", out_valid, 0);
        check("empty_pop_y",     out_y,     32'h8000_0000);

        // Subtract to zero: push into empty lands in head while out_ready=1
        drive(3'b001, 32'h5, 32'h5, 32'h0);
        tick();
        check("sub_out_valid", out_valid, 1);
        check("sub_out_y",     out_y,     0);
        check("sub_flags",     out_flags, 4'b1010);
        // Decrement 0: push and pop together with one entry
        drive(3'b110, 32'h0, 32'h0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        check("dec_out_valid", out_valid, 1);
        check("dec_out_y",     out_y,     32'hFFFF_FFFF);
        check("dec_flags",     out_flags, 4'b0100);
        check("dec_out_sel",   out_sel,   3'b110);
        tick();
        check("dec_drain", out_valid, 0);
        check("dec_count", op_count,  3);

        // Backpressure: 3 back-to-back results with consumer stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(3'b010, 32'(k - 1), 32'h1, 32'(k));
            check($sformatf("bp_in_ready_%0d", k), in_ready, (k <= 2) ? 1 : 0);
            tick();
        end
        check("bp_held_in_ready", in_ready, 0);
        check("bp_head_1",        out_y,    1);
        check("bp_head_1_flags",  out_flags, 4'b0000);
        check("bp_op_count",      op_count, 5);
        out_ready = 1'b1;   // item 3 still presented
        tick();
        check("bp_head_2",     out_y,     2);
        check("bp_in_ready_2", in_ready,  1);
        tick();             // push 3 and pop 2 with one entry
        in_valid = 1'b0;
        check("bp_head_3",     out_y,     3);
        check("bp_valid_3",    out_valid, 1);
        tick();
        check("bp_drained",    out_valid, 0);
        check("bp_op_count_2", op_count,  6);

        // Self-check: wrong result sets sticky error
        drive(3'b011, 32'h1, 32'h1, 32'h2);
        tick();
        in_valid = 1'b0;
        check("selfchk_set", chk_err, 1);
        for (int i = 0; i < 10; i++) begin
            drive(3'b010, 32'(i), 32'(i), 32'(2 * i));
            tick();
        end
        in_valid = 1'b0;
        check("selfchk_sticky", chk_err,  1);
        check("selfchk_count",  op_count, 17);
        tick();

        // Reset mid-operation with two entries buffered
        out_ready = 1'b0;
        drive(3'b111, 32'h0, 32'hAA, 32'hAA);
        tick();
        drive(3'b000, 32'hBB, 32'h0, 32'hBB);
        tick();
        check("mid_full_valid", out_valid, 1);
        check("mid_full_ready", in_ready,  0);
        check("mid_full_head",  out_y,     32'hAA);
        drive(3'b000, 32'hCC, 32'h0, 32'hCC);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_valid",   out_valid, 0);
        check("mid_rst_ready",   in_ready,  1);
        check("mid_rst_count",   op_count,  0);
        check("mid_rst_chk_err", chk_err,   0);
        check("mid_rst_out_y",   out_y,     0);
        drive(3'b000, 32'hDD, 32'h0, 32'hDD);
        tick();
        in_valid = 1'b0;
        check("mid_next_y",     out_y,     32'hDD);
        check("mid_next_valid", out_valid, 1);
        check("mid_next_count", op_count,  1);
        out_ready = 1'b1;
        tick();
        check("mid_next_empty", out_valid, 0);

        // Counter saturation: push every cycle well past 2^16-1
        drive(3'b000, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check("sat_op_count", op_count, 16'hFFFF);
        check("sat_chk_err",  chk_err,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_result_stage
